// File: rtl/machine_sequencer_if.sv
// Sequencer handshake bundle: decode/pin requests in, one-hot M/T timing and bus acknowledge out.
interface machine_sequencer_if;
  logic next_m;
  logic set_m1;
  logic n_wait;
  logic n_busrq;
  logic m1, m2, m3, m4, m5;
  logic t1, t2, t3, t4, t5, t6;
  logic tw;
  logic n_busack;

  modport master (
    output next_m, set_m1, n_wait, n_busrq,
    input  m1, m2, m3, m4, m5, t1, t2, t3, t4, t5, t6, tw, n_busack
  );

  modport slave (
    input  next_m, set_m1, n_wait, n_busrq,
    output m1, m2, m3, m4, m5, t1, t2, t3, t4, t5, t6, tw, n_busack
  );
endinterface

// File: rtl/machine_sequencer.sv
// One-hot M1..M5 / T1..T6,Tw timing generator with wait states and M-cycle end requests.
// Bus grant on n_busrq is built only when SEQ_BUSRQ_EN is defined.
module machine_sequencer (
  input logic                clk,
  input logic                reset,
  machine_sequencer_if.slave seq_io
);

  typedef enum logic [2:0] {StT1, StT2, StT3, StT4, StT5, StT6, StTw, StGrant} state_e;

  state_e     state_q, state_d;
  logic [4:0] m_q, m_d, m_next;
  logic [5:0] t_q, t_d;
  logic       tw_q, tw_d;
  logic       nbusack_q, nbusack_d;
  logic       end_req, end_cyc;
`ifdef SEQ_BUSRQ_EN
  logic [4:0] tgt_q, tgt_d;
`else
  logic       unused_busrq;
  assign unused_busrq = seq_io.n_busrq;
`endif

  assign end_req = seq_io.set_m1 | seq_io.next_m;
  // Rotation wraps M5 back to M1; a forced T6 end behaves as next_m.
  assign m_next  = seq_io.set_m1 ? 5'b00001 : {m_q[3:0], m_q[4]};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    nbusack_d = nbusack_q;
    end_cyc   = 1'b0;
`ifdef SEQ_BUSRQ_EN
    tgt_d     = tgt_q;
`endif
    unique case (state_q)
      StT1: state_d = StT2;
      StT2: begin
        if (!seq_io.n_wait) state_d = StTw;
        else if (end_req)   end_cyc = 1'b1;
        else                state_d = StT3;
      end
      StT3: if (end_req) end_cyc = 1'b1; else state_d = StT4;
      StT4: if (end_req) end_cyc = 1'b1; else state_d = StT5;
      StT5: if (end_req) end_cyc = 1'b1; else state_d = StT6;
      StT6: end_cyc = 1'b1;
      StTw: state_d = seq_io.n_wait ? StT3 : StTw;
      StGrant: begin
`ifdef SEQ_BUSRQ_EN
        if (seq_io.n_busrq) begin
          state_d   = StT1;
          m_d       = tgt_q;
          nbusack_d = 1'b1;
        end
`else
        state_d = StT1;
`endif
      end
    endcase

    if (end_cyc) begin
      state_d = StT1;
      m_d     = m_next;
`ifdef SEQ_BUSRQ_EN
      // Bus is only granted between M-cycles; park the target until release.
      if (!seq_io.n_busrq) begin
        state_d   = StGrant;
        m_d       = '0;
        tgt_d     = m_next;
        nbusack_d = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    t_d  = '0;
    tw_d = 1'b0;
    unique case (state_d)
      StT1:    t_d[0] = 1'b1;
      StT2:    t_d[1] = 1'b1;
      StT3:    t_d[2] = 1'b1;
      StT4:    t_d[3] = 1'b1;
      StT5:    t_d[4] = 1'b1;
      StT6:    t_d[5] = 1'b1;
      StTw:    tw_d   = 1'b1;
      StGrant: t_d    = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StT1;
      m_q       <= 5'b00001;
      t_q       <= 6'b000001;
      tw_q      <= 1'b0;
      nbusack_q <= 1'b1;
`ifdef SEQ_BUSRQ_EN
      tgt_q     <= 5'b00001;
`endif
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      t_q       <= t_d;
      tw_q      <= tw_d;
      nbusack_q <= nbusack_d;
`ifdef SEQ_BUSRQ_EN
      tgt_q     <= tgt_d;
`endif
    end
  end

  assign seq_io.m1       = m_q[0];
  assign seq_io.m2       = m_q[1];
  assign seq_io.m3       = m_q[2];
  assign seq_io.m4       = m_q[3];
  assign seq_io.m5       = m_q[4];
  assign seq_io.t1       = t_q[0];
  assign seq_io.t2       = t_q[1];
  assign seq_io.t3       = t_q[2];
  assign seq_io.t4       = t_q[3];
  assign seq_io.t5       = t_q[4];
  assign seq_io.t6       = t_q[5];
  assign seq_io.tw       = tw_q;
  assign seq_io.n_busack = nbusack_q;

endmodule

// File: tb/tb_machine_sequencer.sv
// Self-checking bench for machine_sequencer: integer-state reference model, directed and random.
module tb_machine_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  machine_sequencer_if sif ();

  machine_sequencer u_dut (
    .clk   (clk),
    .reset (reset),
    .seq_io(sif)
  );

`ifdef SEQ_BUSRQ_EN
  localparam bit BusEn = 1'b1;
`else
  localparam bit BusEn = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  bit armed = 1'b0;

  // Model: mm = M number (0 in grant), tt = T number, 7 = Tw, 0 = grant.
  int mm = 1;
  int tt = 1;
  int tgt = 1;
  bit ack = 1'b1;

  logic [4:0] dm;
  logic [5:0] dt;
  assign dm = {sif.m5, sif.m4, sif.m3, sif.m2, sif.m1};
  assign dt = {sif.t6, sif.t5, sif.t4, sif.t3, sif.t2, sif.t1};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mm = 1; tt = 1; tgt = 1; ack = 1'b1;
    end else if (tt == 0) begin
      if (sif.n_busrq) begin
        tt = 1; mm = tgt; ack = 1'b1;
      end
    end else if ((tt == 2 || tt == 7) && !sif.n_wait) begin
      tt = 7;
    end else if (tt == 7) begin
      tt = 3;
    end else if ((tt >= 2 && (sif.set_m1 || sif.next_m)) || tt == 6) begin
      int nm;
      nm = sif.set_m1 ? 1 : (mm % 5) + 1;
      if (BusEn && !sif.n_busrq) begin
        tgt = nm; mm = 0; tt = 0; ack = 1'b0;
      end else begin
        mm = nm; tt = 1;
      end
    end else begin
      tt = tt + 1;
    end
  end

  function automatic logic [4:0] m_vec(int m);
    logic [4:0] v;
    v = '0;
    if (m >= 1 && m <= 5) v[m-1] = 1'b1;
    return v;
  endfunction

  function automatic logic [5:0] t_vec(int t);
    logic [5:0] v;
    v = '0;
    if (t >= 1 && t <= 6) v[t-1] = 1'b1;
    return v;
  endfunction

  task automatic check(string name, int em, int et, bit eack);
    total++;
    if (dm !== m_vec(em) || dt !== t_vec(et) || sif.tw !== (et == 7) || sif.n_busack !== eack) begin
      bad++;
      $display("FAIL %s @%0t: got M=%b T=%b Tw=%b nBUSACK=%b, want M=%b T=%b Tw=%b nBUSACK=%b",
               name, $time, dm, dt, sif.tw, sif.n_busack, m_vec(em), t_vec(et), et == 7, eack);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (armed) begin
      check("model", mm, tt, ack);
      total++;
      if (!(($onehot(dm) && $onehot({dt, sif.tw})) ||
            (dm == 5'b0 && {dt, sif.tw} == 7'b0 && sif.n_busack == 1'b0))) begin
        bad++;
        $display("FAIL onehot @%0t: got M=%b T=%b Tw=%b nBUSACK=%b, want one-hot M and T/Tw",
                 $time, dm, dt, sif.tw, sif.n_busack);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    sif.next_m = 1'b0; sif.set_m1 = 1'b0; sif.n_wait = 1'b1; sif.n_busrq = 1'b1;
  endtask

  // Steer the model (and DUT) to M gm / T gt using next_m only.
  task automatic goto(int gm, int gt);
    bit found;
    found = 1'b0;
    idle_inputs();
    for (int i = 0; i < 60; i++) begin
      if (mm == gm && tt == gt) begin
        found = 1'b1;
        break;
      end
      sif.next_m = !(mm == gm && tt < gt);
      tick();
    end
    sif.next_m = 1'b0;
    total++;
    if (!found) begin
      bad++;
      $display("FAIL goto: got M%0d T%0d, want M%0d T%0d within 60 clocks", mm, tt, gm, gt);
    end
  endtask

  initial begin
    idle_inputs();
    #3 reset = 1'b1;
    armed = 1'b1;
    #1 check("reset assert", 1, 1, 1'b1);
    tick(); tick();
    reset = 1'b0;
    tick(); check("release", 1, 2, 1'b1);
    for (int k = 3; k <= 6; k++) begin
      tick(); check("free run", 1, k, 1'b1);
    end
    tick(); check("forced end", 2, 1, 1'b1);

    sif.set_m1 = 1'b1;
    tick(); check("setM1 in T1", 2, 2, 1'b1);
    tick(); check("setM1 in T2", 1, 1, 1'b1);
    goto(1, 4);
    sif.set_m1 = 1'b1;
    tick(); check("setM1 in T4", 1, 1, 1'b1);
    goto(3, 3);
    sif.next_m = 1'b1;
    tick(); check("nextM M3 T3", 4, 1, 1'b1);
    goto(5, 3);
    sif.next_m = 1'b1;
    tick(); check("nextM M5 wrap", 1, 1, 1'b1);

    goto(1, 2);
    sif.n_wait = 1'b0;
    tick(); check("wait 1", 1, 7, 1'b1);
    sif.set_m1 = 1'b1;
    tick(); check("wait 2", 1, 7, 1'b1);
    sif.n_wait = 1'b1;
    tick(); check("wait exit", 1, 3, 1'b1);
    sif.set_m1 = 1'b0;

    goto(2, 3);
    sif.set_m1 = 1'b1; sif.n_busrq = 1'b0;
`ifdef SEQ_BUSRQ_EN
    tick(); check("grant entry", 0, 0, 1'b0);
    sif.set_m1 = 1'b0;
    tick(); check("grant hold", 0, 0, 1'b0);
    tick(); check("grant hold", 0, 0, 1'b0);
    sif.n_busrq = 1'b1;
    tick(); check("grant exit", 1, 1, 1'b1);
`else
    tick(); check("no grant", 1, 1, 1'b1);
    sif.set_m1 = 1'b0;
    tick(); check("no grant", 1, 2, 1'b1);
    tick(); check("no grant", 1, 3, 1'b1);
    sif.n_busrq = 1'b1;
    tick(); check("no grant", 1, 4, 1'b1);
`endif

    goto(3, 4);
    reset = 1'b1;
    #1 check("reset mid M3", 1, 1, 1'b1);
    tick();
    reset = 1'b0;
    tick(); check("release M3", 1, 2, 1'b1);

    goto(2, 2);
    sif.next_m = 1'b1; sif.n_busrq = 1'b0;
    tick();
`ifdef SEQ_BUSRQ_EN
    check("grant before reset", 0, 0, 1'b0);
`endif
    reset = 1'b1;
    #1 check("reset mid grant", 1, 1, 1'b1);
    idle_inputs();
    tick();
    reset = 1'b0;
    tick(); check("release grant", 1, 2, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      sif.next_m  = ($urandom_range(0, 3) == 0);
      sif.set_m1  = ($urandom_range(0, 7) == 0);
      sif.n_wait  = ($urandom_range(0, 3) != 0);
      sif.n_busrq = ($urandom_range(0, 3) != 0);
      reset       = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
